// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: menu/serve/rally/point/pause/game-over flow, scores,
// and the ball/layer control bits. Every output is registered.
module pong_game_ctrl #(
  parameter int MAX_SCORE    = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int OVER_FRAMES  = 300,
  parameter int CNT_W        = 9
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       goal_left,
  input  logic       goal_right,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] state,
  output logic       ball_run,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic       show_menu,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    S_MENU   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_POINT  = 3'd3,
    S_PAUSED = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_FRAMES - 1);
  localparam logic [3:0]       WIN_SCORE  = 4'(MAX_SCORE);

  state_t           st_q, st_d;
  logic [1:0]       start_hist, pause_hist;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             ret_play_q, ret_play_d;
  logic [3:0]       s1_d, s2_d, s1_inc, s2_inc;
  logic             dir_d, win_d, run_d, brst_d, menu_d, over_d;
  logic             start_press, pause_press;

  // A press is the second consecutive high sample after a low one.
  assign start_press = frame_tick && start_btn && (start_hist == 2'b01);
  assign pause_press = frame_tick && pause_btn && (pause_hist == 2'b01);

  assign cnt_inc = (frame_tick && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  assign s1_inc  = (score1 == 4'hF) ? 4'hF : score1 + 4'd1;
  assign s2_inc  = (score2 == 4'hF) ? 4'hF : score2 + 4'd1;
  assign state   = st_q;

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_inc;
    ret_play_d = ret_play_q;
    s1_d       = score1;
    s2_d       = score2;
    dir_d      = serve_dir;
    win_d      = winner;
    case (st_q)
      S_MENU: if (start_press) begin
        st_d  = S_SERVE;
        cnt_d = '0;
        s1_d  = 4'd0;
        s2_d  = 4'd0;
        dir_d = 1'b0;
        win_d = 1'b0;
      end
      S_SERVE: begin
        if (pause_press) begin
          st_d       = S_PAUSED;
          ret_play_d = 1'b0;
          cnt_d      = cnt_q;
        end else if (frame_tick && cnt_q == SERVE_LAST) begin
          st_d  = S_PLAY;
          cnt_d = '0;
        end
      end
      S_PLAY: begin
        if (goal_left ^ goal_right) begin
          cnt_d = '0;
          if (goal_right) begin
            s1_d  = s1_inc;
            dir_d = 1'b1;
            if (s1_inc == WIN_SCORE) begin
              st_d  = S_OVER;
              win_d = 1'b0;
            end else st_d = S_POINT;
          end else begin
            s2_d  = s2_inc;
            dir_d = 1'b0;
            if (s2_inc == WIN_SCORE) begin
              st_d  = S_OVER;
              win_d = 1'b1;
            end else st_d = S_POINT;
          end
        end else if (pause_press) begin
          st_d       = S_PAUSED;
          ret_play_d = 1'b1;
          cnt_d      = cnt_q;
        end
      end
      S_POINT: if (frame_tick && cnt_q == POINT_LAST) begin
        st_d  = S_SERVE;
        cnt_d = '0;
      end
      S_PAUSED: begin
        // Counter frozen so a paused serve resumes its countdown.
        cnt_d = cnt_q;
        if (pause_press) st_d = ret_play_q ? S_PLAY : S_SERVE;
      end
      S_OVER: if (start_press || (frame_tick && cnt_q == OVER_LAST)) begin
        st_d  = S_MENU;
        cnt_d = '0;
      end
      default: begin
        st_d  = S_MENU;
        cnt_d = '0;
      end
    endcase
    run_d  = (st_d == S_PLAY);
    brst_d = !((st_d == S_PLAY) || (st_d == S_POINT) ||
               ((st_d == S_PAUSED) && ret_play_d));
    menu_d = (st_d == S_MENU);
    over_d = (st_d == S_OVER);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q       <= S_MENU;
      cnt_q      <= '0;
      ret_play_q <= 1'b0;
      start_hist <= 2'b00;
      pause_hist <= 2'b00;
      score1     <= 4'd0;
      score2     <= 4'd0;
      serve_dir  <= 1'b0;
      winner     <= 1'b0;
      ball_run   <= 1'b0;
      ball_reset <= 1'b1;
      show_menu  <= 1'b1;
      game_over  <= 1'b0;
    end else begin
      if (frame_tick) begin
        start_hist <= {start_hist[0], start_btn};
        pause_hist <= {pause_hist[0], pause_btn};
      end
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      ret_play_q <= ret_play_d;
      score1     <= s1_d;
      score2     <= s2_d;
      serve_dir  <= dir_d;
      winner     <= win_d;
      ball_run   <= run_d;
      ball_reset <= brst_d;
      show_menu  <= menu_d;
      game_over  <= over_d;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed walk through the match flow, then random buttons/goals/ticks,
// all checked against a behavioural model of the game rules.
module tb_pong_game_ctrl;
  localparam int SF = 2, PF = 2, OF = 4, MS = 3;

  logic clock = 1'b0, reset_n = 1'b0;
  logic frame_tick = 0, start_btn = 0, pause_btn = 0, goal_left = 0, goal_right = 0;
  logic [3:0] score1, score2;
  logic [2:0] state;
  logic ball_run, ball_reset, serve_dir, show_menu, game_over, winner;

  pong_game_ctrl #(.MAX_SCORE(MS), .SERVE_FRAMES(SF), .POINT_FRAMES(PF),
                   .OVER_FRAMES(OF), .CNT_W(9)) dut (
    .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick),
    .start_btn(start_btn), .pause_btn(pause_btn), .goal_left(goal_left),
    .goal_right(goal_right), .score1(score1), .score2(score2), .state(state),
    .ball_run(ball_run), .ball_reset(ball_reset), .serve_dir(serve_dir),
    .show_menu(show_menu), .game_over(game_over), .winner(winner));

  always #5 clock = ~clock;

  int n_vec = 0, n_err = 0;

  // game model: state codes 0..5, ret = state to resume after pause
  int m_st, m_s1, m_s2, m_dir, m_win, m_cnt, m_ret, run_s, run_p;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0;
    m_cnt = 0; m_ret = 1; run_s = 0; run_p = 0;
  endtask

  function automatic int exp_flags();
    int brst;
    brst = (m_st == 0 || m_st == 1 || m_st == 5 || (m_st == 4 && m_ret == 1)) ? 1 : 0;
    return {29'd0, 1'b0} | ((m_st == 2) << 5) | (brst << 4) | (m_dir << 3) |
           ((m_st == 0) << 2) | ((m_st == 5) << 1) | m_win;
  endfunction

  task automatic model_step(input bit tk, input bit st, input bit pa,
                            input bit gl, input bit gr);
    bit ps, pp, cleared, frozen;
    // press = button seen high on exactly two consecutive ticks
    ps = tk && st && run_s == 1;
    pp = tk && pa && run_p == 1;
    if (tk) begin
      run_s = st ? (run_s < 3 ? run_s + 1 : 3) : 0;
      run_p = pa ? (run_p < 3 ? run_p + 1 : 3) : 0;
    end
    cleared = 0; frozen = 0;
    case (m_st)
      0: if (ps) begin m_st = 1; m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0; cleared = 1; end
      1: if (pp) begin m_st = 4; m_ret = 1; frozen = 1; end
         else if (tk && m_cnt == SF - 1) begin m_st = 2; cleared = 1; end
      2: if (gl != gr) begin
           cleared = 1;
           if (gr) begin
             m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_dir = 1;
             if (m_s1 == MS) begin m_st = 5; m_win = 0; end else m_st = 3;
           end else begin
             m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; m_dir = 0;
             if (m_s2 == MS) begin m_st = 5; m_win = 1; end else m_st = 3;
           end
         end else if (pp) begin m_st = 4; m_ret = 2; frozen = 1; end
      3: if (tk && m_cnt == PF - 1) begin m_st = 1; cleared = 1; end
      4: begin frozen = 1; if (pp) m_st = m_ret; end
      5: if (ps || (tk && m_cnt == OF - 1)) begin m_st = 0; cleared = 1; end
      default: ;
    endcase
    if (cleared) m_cnt = 0;
    else if (!frozen && tk && m_cnt < 511) m_cnt++;
  endtask

  task automatic step(input bit tk, input bit st, input bit pa,
                      input bit gl, input bit gr);
    frame_tick = tk; start_btn = st; pause_btn = pa; goal_left = gl; goal_right = gr;
    model_step(tk, st, pa, gl, gr);
    @(posedge clock); #1;
    chk("state", int'(state), m_st);
    chk("score1", int'(score1), m_s1);
    chk("score2", int'(score2), m_s2);
    chk("flags", int'({ball_run, ball_reset, serve_dir, show_menu, game_over, winner}),
        exp_flags());
  endtask

  task automatic frames(input int n, input bit st, input bit pa);
    for (int i = 0; i < n; i++) begin
      step(1, st, pa, 0, 0);
      step(0, st, pa, 0, 0);
    end
  endtask

  initial begin
    model_reset();
    #22 reset_n = 1'b1;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_flags", int'({ball_run, ball_reset, serve_dir, show_menu, game_over, winner}), 6'b010100);
    @(posedge clock); #1;
    frames(10, 0, 0);                 // idle in menu
    frames(2, 1, 0);                  // start press -> SERVE
    frames(2, 0, 0);                  // serve countdown -> PLAY
    step(0, 0, 0, 0, 1);              // point to P1 -> POINT
    frames(4, 0, 0);                  // -> SERVE -> PLAY
    for (int g = 0; g < 3; g++) begin // P2 wins; last loop's frames return to MENU
      step(0, 0, 0, 1, 0);
      frames(4, 0, 0);
    end
    frames(2, 1, 0);                  // new match, scores cleared
    frames(2, 0, 0);
    step(0, 0, 0, 1, 1);              // simultaneous goals ignored
    frames(2, 0, 1);                  // pause
    step(0, 0, 0, 0, 1);              // goal ignored while paused
    frames(3, 1, 0);                  // start held during pause: no effect
    frames(2, 0, 1);                  // resume
    step(0, 0, 0, 0, 1); frames(4, 0, 0);
    step(0, 0, 0, 0, 1); frames(4, 0, 0);
    chk("pre_rst_s1", int'(score1), 2);
    // asynchronous reset between clock edges
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_state", int'(state), 0);
    chk("arst_s1", int'(score1), 0);
    chk("arst_brst", int'(ball_reset), 1);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    begin
      bit st, pa;
      st = 0; pa = 0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 7) == 0) st = ~st;
        if ($urandom_range(0, 7) == 0) pa = ~pa;
        step(($urandom_range(0, 2) == 0), st, pa,
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
